race_sequencer: RTL
===================

# race_sequencer

Game-flow controller for the racing game: owns the 30 Hz frame tick, sequences idle → countdown → race → crash → game-over, and drives the car controller's `reset_game` and movement enable. It performs the car/obstacle bounding-box collision test, keeps lives and a frame-based score, and sits between the key inputs, the car/obstacle position registers and the VGA overlay that renders state, countdown, lives and score.

## Interface

**Parameters**
- `FRAME_DIV`, default 833333: iVGA_CLK cycles per frame tick (25 MHz / 30 Hz).
- `CD_STEP_FRAMES`, default 30: frames per countdown digit (3 digits).
- `CRASH_FRAMES`, default 60: frames spent frozen after a collision.
- `LIVES`, default 3: lives loaded at game start (1..3).
- `CAR_W` / `CAR_H`, default 50 / 80: car box size in pixels.
- `OBS_W` / `OBS_H`, default 50 / 80: obstacle box size in pixels.

**Ports**
- `iVGA_CLK` in 1: pixel clock, all logic on the rising edge.
- `iRST` in 1: asynchronous, active-high reset.
- `start_btn` in 1: level input, active-high, synchronous to iVGA_CLK; only rising edges are acted on.
- `car_h_pos` in 10, `car_v_pos` in 9: car top-left corner.
- `obs_h_pos` in 10, `obs_v_pos` in 9: obstacle top-left corner.
- `reset_game` out 1: holds the car controller at its start position.
- `move_en` out 1: car may move and obstacles may scroll.
- `frame_tick` out 1: one-cycle pulse per frame.
- `state` out 3: 0 IDLE, 1 COUNTDOWN, 2 RACE, 3 CRASH, 4 OVER, 5 PAUSE.
- `countdown` out 2: digit to display (3, 2 or 1) in COUNTDOWN, otherwise 0.
- `lives` out 2: remaining lives.
- `score` out 16: frames survived, saturating.

## Operation

- **Frame divider:** free-running counter 0..FRAME_DIV-1, never gated by state. `frame_tick` = 1 for the cycle after the counter equals FRAME_DIV-1.
- **Start edge:** `start_edge` = `start_btn` & ~`start_btn_q`, where `start_btn_q` is a register.
- **Overlap test** is combinational, with 11-bit sums:
  - `car_h` < `obs_h`+OBS_W, and
  - `obs_h` < `car_h`+CAR_W, and
  - `car_v` < `obs_v`+OBS_H, and
  - `obs_v` < `car_v`+CAR_H.
  - Edge-touching boxes do not collide.
- **IDLE:** `reset_game`=1, `move_en`=0. On `start_edge` → COUNTDOWN, with `lives`←LIVES, `score`←0, frame count←0.
- **COUNTDOWN:** `reset_game`=1, `move_en`=0.
  - Counts frame ticks; `countdown` = 3 − (count / CD_STEP_FRAMES).
  - On the tick that brings the count to 3·CD_STEP_FRAMES → RACE.
- **RACE:** `reset_game`=0, `move_en`=1.
  - On each `frame_tick`: if overlap → CRASH, `lives`−1, frame count←0; else `score`+1, saturating at 65535.
  - The crashing tick does not add score.
- **CRASH:** `reset_game`=0, `move_en`=0; the car stays frozen at the impact position.
  - After CRASH_FRAMES ticks: if `lives`==0 → OVER, else → COUNTDOWN with frame count←0.
  - `score` is kept across lives.
- **OVER:** `reset_game`=0, `move_en`=0; `score` and `lives`=0 are held for display. On `start_edge` → COUNTDOWN with a new game (lives reload, score clear).
- `start_edge` is ignored in COUNTDOWN and CRASH, and in RACE unless PAUSE is compiled in.
- **Reset mid-operation:** all state and outputs return to their reset values immediately.

## Timing

- **Reset values:**
  - `state`=IDLE, `reset_game`=1, `move_en`=0, `frame_tick`=0.
  - `countdown`=0, `lives`=LIVES, `score`=0.
  - Divider=0, frame count=0, `start_btn_q`=0.
- All outputs are registered. A condition sampled at edge N is visible on the outputs after edge N.
- **Start latency:** `start_btn` rises before edge N; `state`=COUNTDOWN after edge N+1. This covers one cycle for `start_btn_q` and one for the state register.
- **Collision** is sampled only in the cycle `frame_tick`=1. `state`=CRASH and the `lives` decrement appear together on the next edge, and `move_en` falls on that same edge.
- **Countdown → RACE:** `move_en` rises and `reset_game` falls on the same edge.
- Only one transition happens per cycle. Overlap on the final countdown tick has no effect, since collision is checked only in RACE.

## Configuration

- **Macro `RACE_SEQUENCER_PAUSE_EN` defined:**
  - `start_edge` in RACE → PAUSE: `move_en`=0, `reset_game`=0, score frozen, no collision check.
  - `start_edge` in PAUSE → RACE on the next edge.
  - The divider keeps running throughout.
- **Not defined:** PAUSE is unreachable, and `start_edge` in RACE is ignored.

## Test plan

All scenarios use FRAME_DIV=4, CD_STEP_FRAMES=2, CRASH_FRAMES=3, LIVES=2.

- **Reset:** assert `iRST` mid-RACE → `state`=0, `reset_game`=1, `move_en`=0, `score`=0, `lives`=2 with no clock edge needed; `frame_tick` pulses every 4 cycles after release.
- **Start and countdown:** `start_btn` held high for 20 cycles → a single COUNTDOWN entry; `countdown` reads 3,3,2,2,1,1 across ticks; RACE entered on the 6th tick with `move_en`=1.
- **Survival:** car (295,400), obstacle (100,0), 10 ticks in RACE → `score`=10, `lives`=2, `state`=2.
- **Collision and recovery:** obstacle moved to (300,380) → CRASH on the next tick, `lives`=1, `score` unchanged; after 3 ticks → COUNTDOWN with `reset_game`=1.
- **Edge touch vs. game over:**
  - Obstacle at (345,400) (touching the car's right edge) → no crash.
  - Obstacle at (344,400) → crash; with `lives`=1 → OVER after 3 ticks, `lives`=0.
  - `start_edge` in OVER → COUNTDOWN with `lives`=2, `score`=0.
- **Pause (macro defined):** `start_edge` in RACE at `score`=5 → `state`=5; 8 ticks later `score`=5 with an overlapping obstacle and no crash; `start_edge` → RACE.

Source files
------------

// File: rtl/race_sequencer.sv
// Game-flow controller: 30 Hz frame tick, idle/countdown/race/crash/over sequencing,
// bounding-box collision, lives and score. Optional pause state: RACE_SEQUENCER_PAUSE_EN.
module race_sequencer #(
    parameter int FRAME_DIV      = 833333,
    parameter int CD_STEP_FRAMES = 30,
    parameter int CRASH_FRAMES   = 60,
    parameter int LIVES          = 3,
    parameter int CAR_W          = 50,
    parameter int CAR_H          = 80,
    parameter int OBS_W          = 50,
    parameter int OBS_H          = 80
) (
    input  logic        iVGA_CLK,
    input  logic        iRST,
    input  logic        start_btn,
    input  logic [9:0]  car_h_pos,
    input  logic [8:0]  car_v_pos,
    input  logic [9:0]  obs_h_pos,
    input  logic [8:0]  obs_v_pos,
    output logic        reset_game,
    output logic        move_en,
    output logic        frame_tick,
    output logic [2:0]  state,
    output logic [1:0]  countdown,
    output logic [1:0]  lives,
    output logic [15:0] score
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COUNTDOWN = 3'd1;
    localparam logic [2:0] S_RACE      = 3'd2;
    localparam logic [2:0] S_CRASH     = 3'd3;
    localparam logic [2:0] S_OVER      = 3'd4;
    localparam logic [2:0] S_PAUSE     = 3'd5;

    localparam int DIV_W  = $clog2(FRAME_DIV + 1);
    localparam int FC_MAX = (CD_STEP_FRAMES > CRASH_FRAMES) ? CD_STEP_FRAMES : CRASH_FRAMES;
    localparam int FC_W   = $clog2(FC_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [FC_W-1:0]  CD_LAST    = FC_W'(CD_STEP_FRAMES - 1);
    localparam logic [FC_W-1:0]  CRASH_LAST = FC_W'(CRASH_FRAMES - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic             r_start_q;
    logic             r_start_edge;
    logic [2:0]       r_state;
    logic [1:0]       r_digit;
    logic [FC_W-1:0]  r_fcnt;
    logic [1:0]       r_lives;
    logic [15:0]      r_score;
    logic             r_reset_game;
    logic             r_move_en;
    logic [1:0]       r_countdown;

    logic [2:0]       w_state_n;
    logic [1:0]       w_digit_n;
    logic [FC_W-1:0]  w_fcnt_n;
    logic [1:0]       w_lives_n;
    logic [15:0]      w_score_n;
    logic             w_pause_toggle;
    logic             w_overlap;

    logic [10:0] w_car_l, w_car_r, w_car_t, w_car_b;
    logic [10:0] w_obs_l, w_obs_r, w_obs_t, w_obs_b;

    // Free-running frame divider; the tick is the registered terminal count.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_div  <= r_div + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    // The edge is registered so a press costs two cycles before the state reacts.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_start_q    <= 1'b0;
            r_start_edge <= 1'b0;
        end else begin
            r_start_q    <= start_btn;
            r_start_edge <= start_btn & ~r_start_q;
        end
    end

`ifdef RACE_SEQUENCER_PAUSE_EN
    assign w_pause_toggle = r_start_edge;
`else
    assign w_pause_toggle = 1'b0;
`endif

    // Strict compares on 11-bit extents, so boxes that merely touch do not collide.
    assign w_car_l = {1'b0, car_h_pos};
    assign w_car_r = {1'b0, car_h_pos} + 11'(CAR_W);
    assign w_car_t = {2'b00, car_v_pos};
    assign w_car_b = {2'b00, car_v_pos} + 11'(CAR_H);
    assign w_obs_l = {1'b0, obs_h_pos};
    assign w_obs_r = {1'b0, obs_h_pos} + 11'(OBS_W);
    assign w_obs_t = {2'b00, obs_v_pos};
    assign w_obs_b = {2'b00, obs_v_pos} + 11'(OBS_H);

    assign w_overlap = (w_car_l < w_obs_r) && (w_obs_l < w_car_r) &&
                       (w_car_t < w_obs_b) && (w_obs_t < w_car_b);

    always_comb begin
        w_state_n = r_state;
        w_digit_n = r_digit;
        w_fcnt_n  = r_fcnt;
        w_lives_n = r_lives;
        w_score_n = r_score;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (r_start_edge) begin
                    w_state_n = S_COUNTDOWN;
                    w_digit_n = 2'd3;
                    w_fcnt_n  = '0;
                    w_lives_n = LIVES_INIT;
                    w_score_n = 16'd0;
                end
            end
            S_COUNTDOWN: begin
                if (r_tick) begin
                    if (r_fcnt == CD_LAST) begin
                        w_fcnt_n = '0;
                        if (r_digit == 2'd1) begin
                            w_state_n = S_RACE;
                        end else begin
                            w_digit_n = r_digit - 2'd1;
                        end
                    end else begin
                        w_fcnt_n = r_fcnt + FC_W'(1);
                    end
                end
            end
            S_RACE: begin
                if (w_pause_toggle) begin
                    w_state_n = S_PAUSE;
                end else if (r_tick) begin
                    if (w_overlap) begin
                        w_state_n = S_CRASH;
                        w_lives_n = r_lives - 2'd1;
                        w_fcnt_n  = '0;
                    end else if (r_score != 16'hFFFF) begin
                        w_score_n = r_score + 16'd1;
                    end
                end
            end
            S_CRASH: begin
                if (r_tick) begin
                    if (r_fcnt == CRASH_LAST) begin
                        w_fcnt_n = '0;
                        if (r_lives == 2'd0) begin
                            w_state_n = S_OVER;
                        end else begin
                            w_state_n = S_COUNTDOWN;
                            w_digit_n = 2'd3;
                        end
                    end else begin
                        w_fcnt_n = r_fcnt + FC_W'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (w_pause_toggle) begin
                    w_state_n = S_RACE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as it.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_state      <= S_IDLE;
            r_digit      <= 2'd3;
            r_fcnt       <= '0;
            r_lives      <= LIVES_INIT;
            r_score      <= 16'd0;
            r_reset_game <= 1'b1;
            r_move_en    <= 1'b0;
            r_countdown  <= 2'd0;
        end else begin
            r_state      <= w_state_n;
            r_digit      <= w_digit_n;
            r_fcnt       <= w_fcnt_n;
            r_lives      <= w_lives_n;
            r_score      <= w_score_n;
            r_reset_game <= (w_state_n == S_IDLE) || (w_state_n == S_COUNTDOWN);
            r_move_en    <= (w_state_n == S_RACE);
            r_countdown  <= (w_state_n == S_COUNTDOWN) ? w_digit_n : 2'd0;
        end
    end

    assign frame_tick = r_tick;
    assign state      = r_state;
    assign countdown  = r_countdown;
    assign lives      = r_lives;
    assign score      = r_score;
    assign reset_game = r_reset_game;
    assign move_en    = r_move_en;

endmodule
